// File: rtl/ysyx_25020047_mem_arb.sv
// Shares one handshake pmem port between the IFU and the LSU, with one transaction in flight.
// Responses go back to their owner; a watchdog turns a stalled memory into an error response.
module ysyx_25020047_mem_arb #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter bit          LSU_PRIO = 1'b1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_rsp_valid,
    output logic [DATA_W-1:0]     ifu_rsp_data,
    output logic                  ifu_rsp_err,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_rsp_valid,
    output logic [DATA_W-1:0]     lsu_rsp_data,
    output logic                  lsu_rsp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data
);

    localparam int unsigned MaskW = DATA_W / 8;
    localparam int unsigned WdW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;
    typedef enum logic {OwnIfu, OwnLsu} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_q, last_d;
    logic [WdW-1:0]      wd_q, wd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MaskW-1:0]    wmask_q, wmask_d;
    logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
    logic [DATA_W-1:0]   ifu_rsp_data_q, ifu_rsp_data_d;
    logic                ifu_rsp_err_q, ifu_rsp_err_d;
    logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
    logic [DATA_W-1:0]   lsu_rsp_data_q, lsu_rsp_data_d;
    logic                lsu_rsp_err_q, lsu_rsp_err_d;

    logic                grant_lsu, grant_ifu, idle;
    logic                done, done_err, timeout_hit;
    logic [DATA_W-1:0]   done_data;

    always_comb begin
        if (ifu_req_valid && lsu_req_valid) begin
            grant_lsu = LSU_PRIO ? 1'b1 : (last_q == OwnIfu);
        end else begin
            grant_lsu = lsu_req_valid;
        end
        grant_ifu = ifu_req_valid & ~grant_lsu;
        // Readies are forced low while reset is held so every output reads 0.
        idle          = rst && (state_q == StIdle);
        ifu_req_ready = idle & grant_ifu;
        lsu_req_ready = idle & grant_lsu;
    end

    assign timeout_hit = (TIMEOUT != 0) && (wd_q == WdLast);

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_d          = last_q;
        wd_d            = wd_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        ifu_rsp_valid_d = 1'b0;
        ifu_rsp_data_d  = ifu_rsp_data_q;
        ifu_rsp_err_d   = ifu_rsp_err_q;
        lsu_rsp_valid_d = 1'b0;
        lsu_rsp_data_d  = lsu_rsp_data_q;
        lsu_rsp_err_d   = lsu_rsp_err_q;
        done            = 1'b0;
        done_err        = 1'b0;
        done_data       = '0;

        unique case (state_q)
            StIdle: begin
                if (lsu_req_ready) begin
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    owner_d = OwnLsu;
                    last_d  = OwnLsu;
                    wd_d    = '0;
                    state_d = StReq;
                end else if (ifu_req_ready) begin
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    owner_d = OwnIfu;
                    last_d  = OwnIfu;
                    wd_d    = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                wd_d = wd_q + WdW'(1);
                if (timeout_hit) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else if (mem_req_ready) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                wd_d = wd_q + WdW'(1);
                // A response landing on the timeout cycle still counts as a success.
                if (mem_rsp_valid) begin
                    done      = 1'b1;
                    done_data = (owner_q == OwnLsu && wen_q) ? '0 : mem_rsp_data;
                end else if (timeout_hit) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (done) begin
            state_d = StIdle;
            if (owner_q == OwnLsu) begin
                lsu_rsp_valid_d = 1'b1;
                lsu_rsp_data_d  = done_data;
                lsu_rsp_err_d   = done_err;
            end else begin
                ifu_rsp_valid_d = 1'b1;
                ifu_rsp_data_d  = done_data;
                ifu_rsp_err_d   = done_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            owner_q         <= OwnIfu;
            last_q          <= OwnIfu;
            wd_q            <= '0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            ifu_rsp_valid_q <= 1'b0;
            ifu_rsp_data_q  <= '0;
            ifu_rsp_err_q   <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            lsu_rsp_data_q  <= '0;
            lsu_rsp_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_q          <= last_d;
            wd_q            <= wd_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            ifu_rsp_valid_q <= ifu_rsp_valid_d;
            ifu_rsp_data_q  <= ifu_rsp_data_d;
            ifu_rsp_err_q   <= ifu_rsp_err_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
            lsu_rsp_data_q  <= lsu_rsp_data_d;
            lsu_rsp_err_q   <= lsu_rsp_err_d;
        end
    end

    assign mem_req_valid = (state_q == StReq);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign ifu_rsp_valid = ifu_rsp_valid_q;
    assign ifu_rsp_data  = ifu_rsp_data_q;
    assign ifu_rsp_err   = ifu_rsp_err_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign lsu_rsp_data  = lsu_rsp_data_q;
    assign lsu_rsp_err   = lsu_rsp_err_q;

endmodule

// File: tb/tb_ysyx_25020047_mem_arb.sv
// Directed bench: instance a uses LSU priority with an 8-cycle watchdog, instance b uses
// round-robin with no watchdog; both share the same stimulus.
module tb_ysyx_25020047_mem_arb;

    logic        clk, rst;
    logic        ifu_req_valid, lsu_req_valid, lsu_wen;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rsp_data;
    logic [3:0]  lsu_wmask;
    logic        mem_req_ready, mem_rsp_valid;

    logic        a_ifu_req_ready, a_ifu_rsp_valid, a_ifu_rsp_err;
    logic        a_lsu_req_ready, a_lsu_rsp_valid, a_lsu_rsp_err;
    logic [31:0] a_ifu_rsp_data, a_lsu_rsp_data, a_mem_addr, a_mem_wdata;
    logic        a_mem_req_valid, a_mem_wen;
    logic [3:0]  a_mem_wmask;
    logic        b_ifu_req_ready, b_ifu_rsp_valid, b_ifu_rsp_err;
    logic        b_lsu_req_ready, b_lsu_rsp_valid, b_lsu_rsp_err;
    logic [31:0] b_ifu_rsp_data, b_lsu_rsp_data, b_mem_addr, b_mem_wdata;
    logic        b_mem_req_valid, b_mem_wen;
    logic [3:0]  b_mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_25020047_mem_arb #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(1'b1), .TIMEOUT(8)) u_a (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(a_ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(a_ifu_rsp_valid), .ifu_rsp_data(a_ifu_rsp_data),
        .ifu_rsp_err(a_ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(a_lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(a_lsu_rsp_valid), .lsu_rsp_data(a_lsu_rsp_data),
        .lsu_rsp_err(a_lsu_rsp_err),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(a_mem_addr),
        .mem_wen(a_mem_wen), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    ysyx_25020047_mem_arb #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(1'b0), .TIMEOUT(0)) u_b (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(b_ifu_rsp_valid), .ifu_rsp_data(b_ifu_rsp_data),
        .ifu_rsp_err(b_ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(b_lsu_rsp_valid), .lsu_rsp_data(b_lsu_rsp_data),
        .lsu_rsp_err(b_lsu_rsp_err),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(b_mem_addr),
        .mem_wen(b_mem_wen), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic exp_lsu;

        // Reset with both requesters asserting.
        rst = 1'b0;
        clear_inputs();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000;
        tick();
        tick();
        check_eq("rst_a_ctrl", {a_ifu_req_ready, a_lsu_req_ready, a_ifu_rsp_valid,
                 a_lsu_rsp_valid, a_mem_req_valid, a_mem_wen, a_ifu_rsp_err, a_lsu_rsp_err}, 0);
        check_eq("rst_a_data", {a_mem_addr, a_mem_wdata}, 0);
        check_eq("rst_b_ctrl", {b_ifu_req_ready, b_lsu_req_ready, b_mem_req_valid}, 0);
        rst = 1'b1;
        #1;
        check_eq("rel_a_lsu_rdy", a_lsu_req_ready, 1);
        check_eq("rel_a_ifu_rdy", a_ifu_req_ready, 0);
        check_eq("rel_b_lsu_rdy", b_lsu_req_ready, 1);
        tick();
        check_eq("rel_a_memv", a_mem_req_valid, 1);
        check_eq("rel_a_addr", a_mem_addr, 32'h8000_2000);
        check_eq("rel_a_rdy_busy", a_lsu_req_ready, 0);

        // Single fetch at minimum latency.
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
        #1;
        check_eq("f_ifu_rdy", a_ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        check_eq("f_memv", a_mem_req_valid, 1);
        check_eq("f_addr", a_mem_addr, 32'h8000_0000);
        check_eq("f_wen_mask", {a_mem_wen, a_mem_wmask}, 0);
        tick();
        check_eq("f_memv_drop", a_mem_req_valid, 0);
        check_eq("f_no_early", a_ifu_rsp_valid, 0);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0010_0093;
        tick();
        mem_rsp_valid = 1'b0;
        check_eq("f_rspv", a_ifu_rsp_valid, 1);
        check_eq("f_data", a_ifu_rsp_data, 32'h0010_0093);
        check_eq("f_err", a_ifu_rsp_err, 0);
        check_eq("f_lsu_quiet", a_lsu_rsp_valid, 0);
        check_eq("f_b_data", b_ifu_rsp_data, 32'h0010_0093);
        tick();
        check_eq("f_pulse_end", a_ifu_rsp_valid, 0);
        check_eq("f_hold", a_ifu_rsp_data, 32'h0010_0093);

        // Permanent tie: a always grants LSU, b alternates starting with LSU.
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_2000;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0055;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_lsu = ((i % 2) == 0);
            check_eq("tie_a_lsu_rdy", a_lsu_req_ready, 1);
            check_eq("tie_a_ifu_rdy", a_ifu_req_ready, 0);
            check_eq("tie_b_lsu_rdy", b_lsu_req_ready, exp_lsu);
            check_eq("tie_b_ifu_rdy", b_ifu_req_ready, !exp_lsu);
            tick();
            check_eq("tie_b_addr", b_mem_addr, exp_lsu ? 32'h0000_2000 : 32'h0000_1000);
            tick();
            tick();
            check_eq("tie_a_lsu_rsp", {a_lsu_rsp_valid, a_ifu_rsp_valid}, 2'b10);
            check_eq("tie_a_lsu_data", a_lsu_rsp_data, 32'h55);
            check_eq("tie_b_rsp", {b_lsu_rsp_valid, b_ifu_rsp_valid}, {exp_lsu, !exp_lsu});
        end

        // Store with a 5-cycle memory stall; requester inputs change after handshake.
        do_reset();
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        tick();
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        for (int i = 0; i < 5; i++) begin
            check_eq("st_memv", a_mem_req_valid, 1);
            check_eq("st_req", {a_mem_wen, a_mem_wmask, a_mem_addr, a_mem_wdata},
                     {1'b1, 4'hF, 32'h8000_1000, 32'hDEAD_BEEF});
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        check_eq("st_rspv", {a_lsu_rsp_valid, a_ifu_rsp_valid, a_lsu_rsp_err}, 3'b100);
        check_eq("st_data0", a_lsu_rsp_data, 0);

        // Watchdog: memory accepts but never responds.
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004; mem_req_ready = 1'b1;
        mem_rsp_data = 32'hCAFE_F00D;
        tick();
        ifu_req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq("to_quiet", a_ifu_rsp_valid, 0);
            tick();
        end
        check_eq("to_rsp", {a_ifu_rsp_valid, a_ifu_rsp_err, a_lsu_rsp_valid}, 3'b110);
        check_eq("to_data", a_ifu_rsp_data, 0);
        check_eq("to_memv", a_mem_req_valid, 0);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        check_eq("to_pulse_end", a_ifu_rsp_valid, 0);
        tick();
        check_eq("to_stray", {a_ifu_rsp_valid, a_lsu_rsp_valid, a_mem_req_valid}, 0);

        // Response arriving on the very cycle the watchdog fires wins.
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008; mem_req_ready = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0513;
        tick();
        mem_rsp_valid = 1'b0;
        check_eq("race_rsp", {a_ifu_rsp_valid, a_ifu_rsp_err}, 2'b10);
        check_eq("race_data", a_ifu_rsp_data, 32'h0000_0513);

        // Reset mid-RSP abandons the transaction.
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_000C; mem_req_ready = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check_eq("mid_rst_outs", {a_ifu_rsp_valid, a_mem_req_valid, a_ifu_req_ready}, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_2222;
        tick();
        rst = 1'b1;
        tick();
        check_eq("mid_rst_norsp", {a_ifu_rsp_valid, a_lsu_rsp_valid}, 0);
        check_eq("mid_rst_data", a_ifu_rsp_data, 0);
        mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1;
        #1;
        check_eq("mid_rst_idle", a_ifu_req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25020047_mem_arb.md
Name: ysyx_25020047_mem_arb

Overview:
Two-requester arbiter that shares the single pmem port between the IFU (instruction fetch) and the LSU (load/store) once the core moves to a multi-cycle handshake memory.
- Holds one outstanding transaction at a time.
- Grants by fixed priority or round-robin.
- Routes each response back to its owner.
- Converts a stalled memory into an error response via a watchdog timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (wmask width = DATA_W/8)
LSU_PRIO, 1, 1 = LSU always wins a tie; 0 = round-robin on tie
TIMEOUT, 255, max cycles in REQ+RSP before error response; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  fetch address
ifu_rsp_valid  out  1  one-cycle response pulse to IFU
ifu_rsp_data  out  DATA_W  fetched instruction
ifu_rsp_err  out  1  timeout error, qualified by ifu_rsp_valid
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  load/store address
lsu_wen  in  1  1 = store, 0 = load
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  byte-enable mask
lsu_rsp_valid  out  1  one-cycle response pulse to LSU
lsu_rsp_data  out  DATA_W  load data (0 for stores)
lsu_rsp_err  out  1  timeout error, qualified by lsu_rsp_valid
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  address to memory
mem_wen  out  1  write enable
mem_wdata  out  DATA_W  write data
mem_wmask  out  DATA_W/8  byte mask
mem_rsp_valid  in  1  memory response
mem_rsp_data  in  DATA_W  read data

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE, owner = IFU, last_grant = IFU, watchdog = 0.
  - All outputs = 0.
  - Any in-flight transaction is abandoned; no response is issued for it.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - Grant selection is combinational from the valid inputs.
    - Only one valid: that requester is granted.
    - Both valid, LSU_PRIO=1: LSU is granted.
    - Both valid, LSU_PRIO=0: the requester not equal to last_grant is granted.
  - The granted requester sees its req_ready=1 in this cycle. Handshake = valid&ready.
  - On handshake: register addr/wen/wdata/wmask (IFU: wen=0, wmask=0, wdata=0); set owner and last_grant; go to REQ.
  - req_ready is 0 in REQ and RSP.
- REQ:
  - mem_req_valid=1, with mem_addr/wen/wdata/wmask driven from the registers and held stable.
  - On mem_req_ready=1: go to RSP; mem_req_valid drops next cycle.
- RSP:
  - On mem_rsp_valid=1:
    - Register the owner's rsp_valid=1, rsp_data=mem_rsp_data (LSU store: data 0), err=0 for the next cycle.
    - Go to IDLE.
- Response pulses:
  - rsp_valid is registered and lasts exactly one cycle.
  - The non-owner's rsp_valid stays 0.
  - rsp_data holds its last value when rsp_valid=0.
- Latency:
  - Handshake at cycle T, mem_req_valid at T+1.
  - With mem_req_ready at T+1 and mem_rsp_valid at T+2, owner rsp_valid is at T+3.
  - Minimum is 3 cycles.
- Back-to-back:
  - The arbiter is in IDLE in the same cycle as the rsp pulse, so a new handshake can occur that cycle.
  - Each requester may therefore issue its next request on the cycle it sees its response.
- Watchdog:
  - Counter is cleared on entering REQ and increments every cycle in REQ or RSP.
  - With TIMEOUT≠0, when the count reaches TIMEOUT without completion:
    - Owner gets rsp_valid=1, err=1, data=0.
    - mem_req_valid drops; state returns to IDLE.
  - A late mem_rsp_valid arriving in IDLE or REQ is ignored.
  - TIMEOUT=0: the arbiter waits indefinitely.
- A mem_rsp_valid arriving in the same cycle the timeout fires is treated as a success (err=0, real data).
- Requester inputs are sampled only at handshake; later changes have no effect on the transaction.
- No combinational path from mem_* inputs to requester outputs.

Test Plan:
- Reset: hold rst=0 with both req_valid=1 → all outputs 0. Release rst → at the first edge ifu/lsu handshake per priority, mem_req_valid=1 one cycle later.
- Single fetch: ifu_addr=0x80000000; memory ready immediately, rsp next cycle with 0x00100093 → ifu_rsp_valid pulse at T+3 with data 0x00100093, lsu_rsp_valid=0 throughout.
- Tie, LSU_PRIO=1: both valid every cycle → LSU always granted, IFU starves.
- Tie, LSU_PRIO=0: both valid every cycle → grants alternate LSU, IFU, LSU, IFU (first tie after reset goes to LSU).
- Store: lsu_wen=1, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF → mem outputs match and stay stable while mem_req_ready is held low for 5 cycles; lsu_rsp_valid with data 0 after the response.
- Timeout with TIMEOUT=8: memory never responds → owner rsp_valid with err=1, data 0, 8 cycles after entering REQ. A subsequent stray mem_rsp_valid is ignored. Assert rst=0 mid-RSP in a separate run → immediate IDLE, no response pulse.
